// File: rtl/pt_dec.sv
// pt_dec: PT2272-style OOK frame decoder with repeat-match qualification
//   clk     system clock
//   reset_n synchronous active-low reset
//   din     raw received line (asynchronous)
//   data    last accepted 24 half-bit payload, bit 23 first on the wire
//   valid   one-cycle pulse when data is updated
//   err     one-cycle pulse on an in-frame timing violation
module pt_dec #(
  parameter int ALPHA = 4,
  parameter int REPEAT = 2,
  parameter int CNT_W = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] data,
  output logic        valid,
  output logic        err
);
  typedef enum logic [2:0] {HUNT, ARMED, HIGH, LOW, TAIL, GAP} state_t;
  localparam logic [CNT_W-1:0] W_MIN = CNT_W'(2*ALPHA);
  localparam logic [CNT_W-1:0] W_MID = CNT_W'(8*ALPHA);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(20*ALPHA);
  localparam logic [CNT_W-1:0] W_OVR = CNT_W'(20*ALPHA-1);
  localparam logic [CNT_W-1:0] W_SYN = CNT_W'(64*ALPHA-1);
  localparam logic [2:0] RPT = 3'(REPEAT);
  state_t state, nxt;
  logic s1, ds, ds_d;
  logic [CNT_W-1:0] cnt;
  logic [4:0] idx;
  logic hi_long;
  logic [23:0] sr, prev;
  logic [2:0] mc, mc_n;
  logic rise, fall, tog, is_short, is_long, pair_ok, low_sync, high_over;
  logic shift, done, fault, same, hit;
  assign rise = ds & ~ds_d;
  assign fall = ~ds & ds_d;
  assign tog = ds ^ ds_d;
  // cnt holds the finished phase width on an edge cycle, and the running
  // width minus one on every other cycle
  assign is_short = cnt >= W_MIN && cnt < W_MID;
  assign is_long = cnt >= W_MID && cnt < W_MAX;
  assign pair_ok = hi_long ? is_short : is_long;
  assign low_sync = ~ds & ~tog & (cnt >= W_SYN);
  assign high_over = ds & ~tog & (cnt >= W_OVR);
  assign same = sr == prev;
  assign mc_n = same ? (mc == RPT ? mc : mc + 3'd1) : 3'd1;
  assign hit = done && mc_n == RPT && !(same && mc == RPT);
  always_comb begin
    nxt = state;
    shift = 1'b0;
    done = 1'b0;
    fault = 1'b0;
    case (state)
      HUNT: nxt = low_sync ? ARMED : HUNT;
      ARMED: nxt = rise ? HIGH : ARMED;
      HIGH: begin
        if (high_over || (fall && !(is_short || is_long))) begin
          fault = 1'b1;
          nxt = HUNT;
        end else if (fall) nxt = LOW;
      end
      LOW: begin
        // a low this long is already the next frame's sync
        if (low_sync) begin
          fault = 1'b1;
          nxt = ARMED;
        end else if (rise) begin
          shift = pair_ok;
          fault = ~pair_ok;
          nxt = !pair_ok ? HUNT : (idx == 5'd23 ? TAIL : HIGH);
        end
      end
      TAIL: begin
        if (high_over || (fall && !is_short)) begin
          fault = 1'b1;
          nxt = HUNT;
        end else if (fall) nxt = GAP;
      end
      GAP: begin
        if (rise) begin
          fault = 1'b1;
          nxt = HUNT;
        end else if (low_sync) begin
          done = 1'b1;
          nxt = ARMED;
        end
      end
      default: nxt = HUNT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      ds <= 1'b0;
      ds_d <= 1'b0;
      cnt <= '0;
      state <= HUNT;
      idx <= '0;
      hi_long <= 1'b0;
      sr <= '0;
      prev <= '0;
      mc <= '0;
      data <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      s1 <= din;
      ds <= s1;
      ds_d <= ds;
      cnt <= tog ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
      state <= nxt;
      valid <= hit;
      err <= fault;
      if (state == HIGH && fall) hi_long <= is_long;
      if (state == ARMED && rise) idx <= '0;
      else if (shift) idx <= idx + 5'd1;
      if (shift) sr <= {sr[22:0], hi_long};
      if (done) prev <= sr;
      if (fault) mc <= '0;
      else if (done) mc <= mc_n;
      if (hit) data <= sr;
    end
  end
endmodule

// File: tb/tb_pt_dec.sv
// tb_pt_dec: directed bench for pt_dec with ALPHA=4, REPEAT=2
module tb_pt_dec;
  localparam int S = 16;
  localparam int L = 48;
  localparam int G = 496;
  logic clk = 1'b0;
  logic reset_n, din;
  logic [23:0] data;
  logic valid, err;
  int checks = 0;
  int errors = 0;
  int vcnt = 0, ecnt = 0, both = 0, c71 = 0;
  int v0, e0, c0;
  pt_dec #(.ALPHA(4), .REPEAT(2), .CNT_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .data(data), .valid(valid), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (valid) vcnt++;
    if (err) ecnt++;
    if (valid && err) both++;
    if (data === 24'hC71C71) c71++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    din = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic snap();
    v0 = vcnt;
    e0 = ecnt;
    c0 = c71;
  endtask
  task automatic send_frame(input logic [23:0] p, input int glitch_at, input int rst_at, input int gap);
    for (int i = 0; i < 24; i++) begin
      if (i == rst_at) begin
        din = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, (p[23-i] ? L : S) - 1);
      end else drive(1'b1, p[23-i] ? L : S);
      if (i == glitch_at) begin
        drive(1'b0, S / 2);
        drive(1'b1, 1);
        drive(1'b0, (p[23-i] ? S : L) - S / 2);
      end else drive(1'b0, p[23-i] ? S : L);
    end
    drive(1'b1, S);
    drive(1'b0, gap);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    din = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    drive(1'b0, 500);
    snap();
    send_frame(24'hC71C71, -1, -1, G);
    chk("t1_first_frame_no_valid", vcnt - v0, 0);
    send_frame(24'hC71C71, -1, -1, 0);
    drive(1'b0, 257);
    chk("t1_latency_pre", valid, 0);
    @(negedge clk);
    chk("t1_latency_valid", valid, 1);
    chk("t1_data", data, 24'hC71C71);
    @(negedge clk);
    chk("t1_valid_pulse", valid, 0);
    drive(1'b0, G - 259);
    chk("t1_nvalid", vcnt - v0, 1);
    chk("t1_nerr", ecnt - e0, 0);
    do_reset();
    chk("t2_reset_data", data, 0);
    drive(1'b0, 300);
    snap();
    send_frame(24'hC71C71, -1, -1, G);
    drive(1'b0, 1000);
    chk("t2_nvalid", vcnt - v0, 0);
    chk("t2_data", data, 0);
    do_reset();
    drive(1'b0, 300);
    snap();
    send_frame(24'hC71C71, -1, -1, G);
    send_frame(24'h555555, -1, -1, G);
    chk("t3_mid_nvalid", vcnt - v0, 0);
    send_frame(24'h555555, -1, -1, G);
    chk("t3_nvalid", vcnt - v0, 1);
    chk("t3_data", data, 24'h555555);
    chk("t3_never_c71", c71 - c0, 0);
    chk("t3_nerr", ecnt - e0, 0);
    do_reset();
    drive(1'b0, 300);
    snap();
    for (int k = 0; k < 4; k++) send_frame(24'hFFFFFF, -1, -1, G);
    chk("t4_nvalid4", vcnt - v0, 1);
    chk("t4_data", data, 24'hFFFFFF);
    send_frame(24'hFFFFFF, 5, -1, G);
    chk("t4_glitch_err", ecnt - e0, 1);
    chk("t4_glitch_nvalid", vcnt - v0, 1);
    send_frame(24'hFFFFFF, -1, -1, G);
    chk("t4_after1_nvalid", vcnt - v0, 1);
    send_frame(24'hFFFFFF, -1, -1, G);
    chk("t4_after2_nvalid", vcnt - v0, 2);
    chk("t4_final_nerr", ecnt - e0, 1);
    do_reset();
    drive(1'b0, 300);
    snap();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, S);
      drive(1'b0, L);
    end
    din = 1'b1;
    repeat (81) @(negedge clk);
    chk("t5_err_pre", err, 0);
    @(negedge clk);
    chk("t5_err_cycle80", err, 1);
    @(negedge clk);
    chk("t5_err_pulse", err, 0);
    drive(1'b1, 7);
    drive(1'b0, 300);
    send_frame(24'hA5F00F, -1, -1, G);
    send_frame(24'hA5F00F, -1, -1, G);
    chk("t5_nvalid", vcnt - v0, 1);
    chk("t5_data", data, 24'hA5F00F);
    chk("t5_nerr", ecnt - e0, 1);
    do_reset();
    drive(1'b0, 300);
    snap();
    send_frame(24'h3C3C3C, -1, -1, G);
    send_frame(24'h3C3C3C, -1, 10, G);
    chk("t6_nvalid", vcnt - v0, 0);
    chk("t6_nerr", ecnt - e0, 0);
    chk("t6_data", data, 0);
    send_frame(24'h3C3C3C, -1, -1, G);
    send_frame(24'h3C3C3C, -1, -1, G);
    chk("t6_after_nvalid", vcnt - v0, 1);
    chk("t6_after_data", data, 24'h3C3C3C);
    chk("no_valid_err_overlap", both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pt_dec.md
Name: pt_dec

Overview:
- PT2272-style decoder for the OOK waveform produced by pt_enc.
- Samples the received line on the system clock and classifies pulse widths into 24 half-bits, which it packs into a payload word.
- Publishes the word only after REPEAT consecutive identical frames have arrived.
- Sits between a GPIO receive pin and downstream logic, for example a UART transmit path that echoes decoded codes.

Parameters:
ALPHA, 4, clk cycles per PT2262 oscillator unit α (nominal short = 4α, long = 12α, sync low = 124α)
REPEAT, 2, number of consecutive identical frames required before valid (1..4)
CNT_W, 12, width of the pulse-width counter; saturates at all-ones

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
din  in  1  raw received line, asynchronous to clk
data  out  24  last accepted payload; bit 23 = first half-bit on the wire
valid  out  1  one-cycle pulse when data is updated
err  out  1  one-cycle pulse on a timing violation inside a frame

Behaviour:
- Reset (reset_n low at a clk edge): data=0, valid=0, err=0, state=HUNT, all counters and match count cleared. The synchronizer flops are cleared to 0. A reset applied mid-frame discards that frame with no err pulse.
- Input path: 2-flop synchronizer on din, then an edge detect on the synchronized signal (ds). All widths are measured on ds, in clk cycles from edge to edge. The width counter saturates and never wraps.
- Width classes, with w = measured width:
  - SHORT: 2·ALPHA ≤ w < 8·ALPHA
  - LONG: 8·ALPHA ≤ w < 20·ALPHA
  - SYNC (low phase only): w ≥ 64·ALPHA
  - Anything else is BAD. A high phase reaching 20·ALPHA is BAD immediately, without waiting for the falling edge.
- Half-bit decode: a high phase followed by the subsequent low phase forms one half-bit.
  - SHORT high + LONG low = 0.
  - LONG high + SHORT low = 1.
  - Any other combination is an error.
  - Tri-state symbols map to half-bit pairs as 0=00, 1=11, F=01. Pair 10 is accepted unchanged.
- States:
  - HUNT: ignore everything until ds has been low for 64·ALPHA cycles; then go to ARMED. No err pulses are issued in HUNT.
  - ARMED: wait for a rising edge; then go to HIGH with bit index 0.
  - HIGH: measure the high phase. On the falling edge, go to LOW if the width is SHORT or LONG. If it is BAD, pulse err and go to HUNT.
  - LOW: measure the low phase.
    - Bits 0..23: on the rising edge, if the pair is legal, shift the half-bit into the shift register, increment the index, and go to HIGH.
    - Illegal pair: pulse err and go to HUNT.
    - Low reaches 64·ALPHA while index < 24: pulse err and go directly to ARMED, because the gap is itself a valid sync.
  - TAIL (after 24 half-bits): expect a SHORT high (the sync pulse).
    - SHORT high: go to GAP.
    - Any other width: pulse err and go to HUNT.
  - GAP: low reaching 64·ALPHA completes the frame; then go to ARMED. A rising edge before that point is an error: pulse err and go to HUNT.
- Frame completion:
  - If the shift register equals the previous completed frame, increment the match count (saturating at REPEAT); otherwise load the match count with 1.
  - When the match count reaches REPEAT on this completion, data <= shift register and valid pulses in the same cycle.
  - Further identical frames do not re-pulse valid until a different frame or an err intervenes. err clears the match count.
- Latency: valid asserts on the clk edge where the synchronized low count equals 64·ALPHA, which is 64·ALPHA+2 cycles after the raw din falling edge of the sync pulse.
- data holds its value until the next valid; err never alters data.
- valid and err are never asserted in the same cycle.

Test Plan:
- Reset, ALPHA=4, REPEAT=2: drive 500 cycles low, then two frames of payload 24'hC71C71 (short=16, long=48, sync low=496 cycles) -> exactly one valid, data=24'hC71C71, err never asserted.
- Same payload sent once, then line idle low -> no valid, data stays 0.
- Frame 24'hC71C71 followed by frame 24'h555555, then 24'h555555 again -> single valid with data=24'h555555; data never shows 24'hC71C71.
- Four identical 24'hFFFFFF frames -> valid pulses once (after frame 2) only; after an injected 1-cycle high glitch mid-frame (err pulse), two more identical frames -> second valid.
- Mid-frame high held for 80 cycles -> err pulse on cycle 80 of the high, state=HUNT; the next two clean frames decode normally.
- reset_n low for 1 cycle during bit 10 of frame 2 -> no err and no valid for that pair; data=0; two subsequent clean frames -> valid.
